blockram_stream_reader: RTL and testbench

//  Read-side engine for blockram: accepts a (start address, length) command, drives

---
 rtl/blockram_stream_reader_pkg.sv | 13 +
 rtl/blockram_stream_reader_fifo2.sv | 44 ++++
 rtl/blockram_stream_reader.sv | 114 +++++++++++
 tb/tb_blockram_stream_reader.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/blockram_stream_reader_pkg.sv
// Shared definitions for the blockram stream reader: FSM states and the
// number of words the reader may own at once (in flight plus buffered).
package blockram_stream_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [2:0] FIFO_DEPTH = 3'd2;

endpackage

// File: rtl/blockram_stream_reader_fifo2.sv
// Two-entry register FIFO holding {last, data} beats between the blockram
// read port and the output stream.
module bram_rd_fifo2 #(
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem [0:1];
  logic             wr_ptr;
  logic             rd_ptr;

  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      if (push && !pop) begin
        count <= count + 2'd1;
      end else if (pop && !push) begin
        count <= count - 2'd1;
      end
    end
  end

endmodule

// File: rtl/blockram_stream_reader.sv
// Blockram read engine: turns an (address, length) command into port-b reads
// and presents the returned words as a valid/ready stream with a last flag.
module blockram_stream_reader
  import blockram_stream_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [ADDR_WIDTH-1:0] cmd_len,
  output logic [ADDR_WIDTH-1:0] ram_addrb,
  output logic                  ram_enb,
  input  logic [DATA_WIDTH-1:0] ram_dob,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic                  busy
);

  localparam logic [ADDR_WIDTH:0] ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t                state;
  state_t                state_next;
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH:0]   reads_left;
  logic                  inflight;
  logic                  inflight_last;
  logic [1:0]            fifo_count;
  logic [DATA_WIDTH:0]   fifo_out;
  logic                  pop;
  logic                  issue;
  logic                  last_issue;
  logic                  accept;
  logic [2:0]            owned;

  assign pop        = m_valid & m_ready;
  assign accept     = cmd_valid & cmd_ready;
  assign last_issue = (reads_left == ONE);
  // Words already committed to the reader once this cycle's pop is taken out.
  assign owned      = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};

  assign cmd_ready  = rst_n && (state == ST_IDLE);
  assign ram_enb    = issue;
  assign ram_addrb  = addr;
  assign m_valid    = (fifo_count != 2'd0);
  assign {m_last, m_data} = fifo_out;
  assign busy       = (state != ST_IDLE) || (fifo_count != 2'd0);

  always_comb begin
    state_next = state;
    issue      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_next = ST_READ;
        end
      end
      ST_READ: begin
        if (owned < FIFO_DEPTH) begin
          issue = 1'b1;
          if (last_issue) begin
            state_next = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (pop && m_last) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // reads_left is one bit wider than the address so a full-memory command fits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      addr          <= '0;
      reads_left    <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      state         <= state_next;
      inflight      <= issue;
      inflight_last <= issue & last_issue;
      if (accept) begin
        addr       <= cmd_addr;
        reads_left <= {1'b0, cmd_len} + ONE;
      end else if (issue) begin
        addr       <= addr + 1'b1;
        reads_left <= reads_left - ONE;
      end
    end
  end

  bram_rd_fifo2 #(
    .WIDTH(DATA_WIDTH + 1)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (inflight),
    .push_data({inflight_last, ram_dob}),
    .pop      (pop),
    .pop_data (fifo_out),
    .count    (fifo_count)
  );

endmodule

// File: tb/tb_blockram_stream_reader.sv
// Scoreboard bench for blockram_stream_reader with a behavioural blockram
// preloaded so that ram[i] = i + 100.
module tb_blockram_stream_reader;

  localparam int DW    = 32;
  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr = '0;
  logic [AW-1:0] cmd_len = '0;
  logic [AW-1:0] ram_addrb;
  logic          ram_enb;
  logic [DW-1:0] ram_dob = '0;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic          m_last;
  logic          busy;

  logic [DW-1:0] ram [0:DEPTH-1];
  logic [DW:0]   q[$];
  int            errors = 0;
  int            checks = 0;
  int            cycle = 0;
  int            issued = 0;
  int            beats = 0;
  int            beat_cnt = 0;
  int            last_cnt = 0;
  int            first_cyc = 0;
  int            last_cyc = 0;
  logic [AW-1:0] exp_addr = '0;
  logic          rand_ready = 1'b0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;

  blockram_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_addr (cmd_addr),
    .cmd_len  (cmd_len),
    .ram_addrb(ram_addrb),
    .ram_enb  (ram_enb),
    .ram_dob  (ram_dob),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_last   (m_last),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < DEPTH; i++) ram[i] = DW'(i + 100);
  end

  always @(posedge clk) begin
    cycle <= cycle + 1;
    if (ram_enb) ram_dob <= ram[ram_addrb];
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  // Monitor: scoreboard compare, stall stability, address order and issue limit.
  always @(negedge clk) begin
    logic       xfer;
    logic [DW:0] e;
    if (!rst_n) begin
      issued     = 0;
      beats      = 0;
      prev_stall = 1'b0;
    end else begin
      xfer = m_valid && m_ready;
      if (prev_stall) begin
        checkOutput("stall_data", 64'(m_data), 64'(prev_data));
        checkOutput("stall_last", 64'(m_last), 64'(prev_last));
      end
      if (ram_enb) begin
        checkOutput("issue_owned", 64'((issued - beats - int'(xfer)) < 2), 64'd1);
        checkOutput("read_addr", 64'(ram_addrb), 64'(exp_addr));
        exp_addr = exp_addr + 1'b1;
        issued++;
      end
      if (xfer) begin
        checkOutput("beat_expected", 64'(q.size() > 0), 64'd1);
        if (q.size() > 0) begin
          e = q.pop_front();
          checkOutput("beat_data", 64'(m_data), 64'(e[DW-1:0]));
          checkOutput("beat_last", 64'(m_last), 64'(e[DW]));
        end
        if (beat_cnt == 0) first_cyc = cycle;
        last_cyc = cycle;
        beat_cnt++;
        if (m_last) last_cnt++;
        beats++;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
    end
  end

  task automatic applyStimulus(input int addr, input int len);
    int n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("cmd_ready_idle", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1;
    cmd_addr  = AW'(addr);
    cmd_len   = AW'(len);
    for (int i = 0; i <= len; i++)
      q.push_back({(i == len), DW'(((addr + i) % DEPTH) + 100)});
    exp_addr = AW'(addr);
    beat_cnt = 0;
    last_cnt = 0;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_addr  = AW'($urandom);
    cmd_len   = AW'($urandom);
  endtask

  task automatic waitIdle(input int budget, input int len, input logic check_rate);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain_pending", 64'(q.size()), 64'd0);
    @(negedge clk);
    checkOutput("busy_after", 64'(busy), 64'd0);
    checkOutput("beat_count", 64'(beat_cnt), 64'(len + 1));
    checkOutput("last_count", 64'(last_cnt), 64'd1);
    if (check_rate) checkOutput("no_bubbles", 64'(last_cyc - first_cyc), 64'(len));
  endtask

  initial begin
    int n;
    logic first_enb;

    #2;
    checkOutput("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    checkOutput("rst_enb", 64'(ram_enb), 64'd0);
    checkOutput("rst_addrb", 64'(ram_addrb), 64'd0);
    checkOutput("rst_valid", 64'(m_valid), 64'd0);
    checkOutput("rst_last", 64'(m_last), 64'd0);
    checkOutput("rst_data", 64'(m_data), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("idle_cmd_ready", 64'(cmd_ready), 64'd1);

    $display("[TB] basic 4-word read from address 5");
    applyStimulus(5, 3);
    n = 0;
    first_enb = 1'b0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) first_enb = ram_enb;
    end while (!m_valid && n < 10);
    checkOutput("enb_first_cycle", 64'(first_enb), 64'd1);
    checkOutput("valid_latency", 64'(n), 64'd3);
    waitIdle(50, 3, 1'b1);

    $display("[TB] address wrap");
    applyStimulus(DEPTH - 2, 3);
    waitIdle(50, 3, 1'b1);

    $display("[TB] random backpressure, ignored command while busy");
    rand_ready = 1'b1;
    applyStimulus(40, 15);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_addr  = AW'(500);
    cmd_len   = AW'(2);
    @(negedge clk);
    cmd_valid = 1'b0;
    waitIdle(400, 15, 1'b0);
    rand_ready = 1'b0;
    @(posedge clk);
    #2;

    $display("[TB] single-word command");
    applyStimulus(7, 0);
    n = 0;
    while (!m_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    checkOutput("single_valid", 64'(m_valid), 64'd1);
    @(negedge clk);
    checkOutput("single_cmd_ready", 64'(cmd_ready), 64'd1);
    waitIdle(10, 0, 1'b1);

    $display("[TB] reset mid-command");
    applyStimulus(10, 15);
    n = 0;
    while (beat_cnt < 4 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("beats_before_reset", 64'(beat_cnt >= 4), 64'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_valid", 64'(m_valid), 64'd0);
    checkOutput("mid_rst_enb", 64'(ram_enb), 64'd0);
    checkOutput("mid_rst_busy", 64'(busy), 64'd0);
    q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 1);
    waitIdle(50, 1, 1'b1);
    repeat (3) @(negedge clk);
    checkOutput("post_reset_quiet", 64'(m_valid), 64'd0);

    $display("[TB] full-memory read");
    applyStimulus(0, DEPTH - 1);
    waitIdle(3000, DEPTH - 1, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
